// File: rtl/debug_display_pkg.sv
// rtl/debug_display_pkg.sv - shared types for the debug display scanner
package debug_display_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    typedef logic [3:0] nibble_t;

endpackage

// File: rtl/channel_sequencer.sv
// rtl/channel_sequencer.sv - channel index register with manual/auto/step selection
module channel_sequencer
    import debug_display_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int DWELL  = 50000000,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [SEL_W-1:0] sel_i,
    input  mode_t            mode_i,
    input  logic             step_i,
    output logic [SEL_W-1:0] index_o,
    output logic             sel_invalid_o
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [SEL_W-1:0] index_q, index_d;
    logic [SEL_W-1:0] index_next;
    logic [SEL_W-1:0] sel_clamped;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_t            mode_q;
    logic             sel_valid;

    // Switch value range check and clamp; the clamp is only used on mode entry
    always_comb begin
        sel_valid   = (32'(sel_i) < NUM_CH);
        sel_clamped = sel_valid ? sel_i : SEL_W'(NUM_CH - 1);
        index_next  = (index_q == SEL_W'(NUM_CH - 1)) ? '0 : index_q + 1'b1;
    end

    // Next index/counter: a mode change reloads from the switches before any advance
    always_comb begin
        index_d = index_q;
        cnt_d   = '0;
        if (mode_i != mode_q) begin
            index_d = sel_clamped;
        end else begin
            case (mode_i)
                MODE_AUTO: begin
                    if (cnt_q == CNT_W'(DWELL - 1)) begin
                        index_d = index_next;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MODE_STEP: begin
                    if (step_i) begin
                        index_d = index_next;
                    end
                end
                default: begin
                    if (sel_valid) begin
                        index_d = sel_i;
                    end
                end
            endcase
        end
    end

    // Index, dwell counter and previous-mode registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            index_q <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_MANUAL;
        end else begin
            index_q <= index_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_i;
        end
    end

    assign index_o       = index_q;
    assign sel_invalid_o = ~sel_valid;

endmodule

// File: rtl/debug_display_scanner.sv
// rtl/debug_display_scanner.sv - debug bus selector with freeze snapshot feeding hex digits
module debug_display_scanner
    import debug_display_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int WIDTH  = 16,
    parameter int DWELL  = 50000000,
    localparam int DIGITS = (WIDTH + 3) / 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CH-1:0][WIDTH-1:0]  channels_i,
    input  logic [SEL_W-1:0]              sel_i,
    input  logic [1:0]                    mode_i,
    input  logic                          step_i,
    input  logic                          freeze_i,
    output logic [DIGITS-1:0][3:0]        digits_o,
    output logic [SEL_W-1:0]              ch_index_o,
    output logic                          frozen_o,
    output logic                          sel_error_o
);

    mode_t                       mode;
    logic [SEL_W-1:0]            index;
    logic                        sel_invalid;
    logic [NUM_CH-1:0][WIDTH-1:0] snap_q;
    logic                        frozen_q;
    logic                        sel_error_q, sel_error_d;
    logic [WIDTH-1:0]            src_word;
    logic [DIGITS*4-1:0]         padded;
    nibble_t [DIGITS-1:0]        digits_q, digits_d;
    logic [SEL_W-1:0]            ch_index_q;

    assign mode = mode_t'(mode_i);

    channel_sequencer #(
        .NUM_CH (NUM_CH),
        .DWELL  (DWELL),
        .SEL_W  (SEL_W)
    ) u_seq (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sel_i         (sel_i),
        .mode_i        (mode),
        .step_i        (step_i),
        .index_o       (index),
        .sel_invalid_o (sel_invalid)
    );

    // Snapshot bank loads on the freeze rising edge and holds otherwise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            snap_q <= '0;
        end else if (freeze_i && !frozen_q) begin
            snap_q <= channels_i;
        end
    end

    // Registered freeze level; doubles as the previous value for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frozen_q <= 1'b0;
        end else begin
            frozen_q <= freeze_i;
        end
    end

    // Source mux, zero-extension to whole nibbles, blanking on a bad switch value
    always_comb begin
        src_word           = frozen_q ? snap_q[index] : channels_i[index];
        padded             = '0;
        padded[WIDTH-1:0]  = src_word;
        digits_d           = sel_error_q ? '0 : padded;
        sel_error_d        = ((mode == MODE_MANUAL) || (mode == MODE_RSVD)) && sel_invalid;
    end

    // Output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            digits_q    <= '0;
            ch_index_q  <= '0;
            sel_error_q <= 1'b0;
        end else begin
            digits_q    <= digits_d;
            ch_index_q  <= index;
            sel_error_q <= sel_error_d;
        end
    end

    assign digits_o    = digits_q;
    assign ch_index_o  = ch_index_q;
    assign frozen_o    = frozen_q;
    assign sel_error_o = sel_error_q;

endmodule
